regfile_arbiter: RTL

Two-port round-robin arbiter and sequencer sharing one synchronous `regfile` (8-bit address, 8-bit data, CS/WE/RD strobes) between two requesters. Each requester issues single-word read or write commands over a req/gnt handshake. The arbiter serialises the commands, drives the regfile strobes for exactly one cycle per access, waits out the read latency and returns read data with a one-cycle valid pulse. It sits directly in front of `regfile`; no other block drives the regfile ports.

---
 rtl/regfile_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/regfile_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_arbiter
//
// Shares one synchronous register file between two requesters. Each requester
// issues single-word read/write commands over a Req/Gnt handshake; a
// round-robin pointer resolves simultaneous requests. One command is in flight
// at a time:
//   IDLE   -> sample requests, latch the winner's command, pulse its Gnt
//   ACCESS -> strobes (CS plus WE or RD) high for exactly this one cycle
//   WAIT   -> reads only: wait RD_LAT cycles, then capture MemDataOut and
//             pulse the owner's Rvalid
//
// Ports
//   Clk, Rst_n             clock (rising edge), asynchronous active-low reset
//   Req0/1, Wr0/1          command request and direction (1 = write)
//   Addr0/1, Wdata0/1      command address and write data
//   Gnt0/1                 one-cycle pulse: command accepted
//   Rvalid0/1, Rdata0/1    one-cycle read-valid pulse, read data (held)
//   MemCS/WE/RD            register file strobes
//   MemAddr, MemDataIn     register file address and write data
//   MemDataOut             register file read data
//
// Every output comes straight from a flop; there is no combinational path
// from any input to any output.
// -----------------------------------------------------------------------------
module regfile_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1     // legal range 1..4
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Req0,
    input  logic              Req1,
    input  logic              Wr0,
    input  logic              Wr1,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [DATA_W-1:0] Wdata0,
    input  logic [DATA_W-1:0] Wdata1,
    output logic              Gnt0,
    output logic              Gnt1,
    output logic              Rvalid0,
    output logic              Rvalid1,
    output logic [DATA_W-1:0] Rdata0,
    output logic [DATA_W-1:0] Rdata1,
    output logic              MemCS,
    output logic              MemWE,
    output logic              MemRD,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemDataIn,
    input  logic [DATA_W-1:0] MemDataOut
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } state_t;

    localparam logic [2:0] LAT_LOAD = 3'(RD_LAT);

    state_t     state_reg;
    logic       last_reg;    // requester granted most recently
    logic       owner_reg;   // requester that owns the command in flight
    logic [2:0] cnt_reg;     // read latency countdown

    logic any_req;
    logic pick;              // winner if a grant happens this cycle

    // Round-robin: on a tie the requester that did not win last time goes.
    always_comb begin
        any_req = Req0 | Req1;
        if (Req0 && Req1) begin
            pick = ~last_reg;
        end else if (Req1) begin
            pick = 1'b1;
        end else begin
            pick = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg <= IDLE;
            last_reg  <= 1'b1;
            owner_reg <= 1'b0;
            cnt_reg   <= 3'd0;
            Gnt0      <= 1'b0;
            Gnt1      <= 1'b0;
            Rvalid0   <= 1'b0;
            Rvalid1   <= 1'b0;
            Rdata0    <= '0;
            Rdata1    <= '0;
            MemCS     <= 1'b0;
            MemWE     <= 1'b0;
            MemRD     <= 1'b0;
            MemAddr   <= '0;
            MemDataIn <= '0;
        end else begin
            // Pulses and strobes default low; only the branches below raise them.
            Gnt0    <= 1'b0;
            Gnt1    <= 1'b0;
            Rvalid0 <= 1'b0;
            Rvalid1 <= 1'b0;
            MemCS   <= 1'b0;
            MemWE   <= 1'b0;
            MemRD   <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        last_reg  <= pick;
                        owner_reg <= pick;
                        MemCS     <= 1'b1;
                        if (pick) begin
                            Gnt1      <= 1'b1;
                            MemWE     <= Wr1;
                            MemRD     <= ~Wr1;
                            MemAddr   <= Addr1;
                            MemDataIn <= Wdata1;
                        end else begin
                            Gnt0      <= 1'b1;
                            MemWE     <= Wr0;
                            MemRD     <= ~Wr0;
                            MemAddr   <= Addr0;
                            MemDataIn <= Wdata0;
                        end
                        state_reg <= ACCESS;
                    end
                end

                ACCESS: begin
                    // MemRD still reflects the command being issued this cycle.
                    if (MemRD) begin
                        cnt_reg   <= LAT_LOAD;
                        state_reg <= WAIT;
                    end else begin
                        state_reg <= IDLE;
                    end
                end

                WAIT: begin
                    if (cnt_reg <= 3'd1) begin
                        cnt_reg <= 3'd0;
                        if (owner_reg) begin
                            Rdata1  <= MemDataOut;
                            Rvalid1 <= 1'b1;
                        end else begin
                            Rdata0  <= MemDataOut;
                            Rvalid0 <= 1'b1;
                        end
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 3'd1;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
